// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned DW = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting two requesters single-cycle access to a
// combinational-read byte memory; one transaction per IDLE/ACCESS pair.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          reset,

   input  logic          r0_valid,
   input  logic          r0_write,
   input  logic [DW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_ready,
   output logic          r0_rsp_valid,
   output logic [DW-1:0] r0_rsp_rdata,

   input  logic          r1_valid,
   input  logic          r1_write,
   input  logic [DW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_ready,
   output logic          r1_rsp_valid,
   output logic [DW-1:0] r1_rsp_rdata,

   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   state_t state, state_nxt;
   logic   last_grant;   // doubles as owner of the transaction in ACCESS
   logic   win;
   logic   hs;

   always_comb begin
      win = 1'b0;
      if (r0_valid && r1_valid)
         win = ~last_grant;
      else if (r1_valid)
         win = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      r0_ready  = 1'b0;
      r1_ready  = 1'b0;
      hs        = 1'b0;
      case (state)
         IDLE: begin
            if (!reset) begin
               r0_ready = r0_valid && !win;
               r1_ready = r1_valid &&  win;
               hs       = r0_ready || r1_ready;
               if (hs)
                  state_nxt = ACCESS;
            end
         end
         ACCESS:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant   <= 1'b1;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         r0_rsp_valid <= 1'b0;
         r1_rsp_valid <= 1'b0;
         r0_rsp_rdata <= '0;
         r1_rsp_rdata <= '0;
      end else begin
         r0_rsp_valid <= 1'b0;
         r1_rsp_valid <= 1'b0;
         if (hs) begin
            last_grant <= win;
            mem_we     <= win ? r1_write : r0_write;
            mem_addr   <= win ? r1_addr  : r0_addr;
            mem_wdata  <= win ? r1_wdata : r0_wdata;
         end else if (state == ACCESS) begin
            // mem_we still carries the latched write flag here
            mem_we <= 1'b0;
            if (last_grant) begin
               r1_rsp_valid <= 1'b1;
               if (!mem_we)
                  r1_rsp_rdata <= mem_rdata;
            end else begin
               r0_rsp_valid <= 1'b1;
               if (!mem_we)
                  r0_rsp_rdata <= mem_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 256-byte memory beside it.
module tb_mem_arbiter;

   logic       clk;
   logic       reset;
   logic       r0_valid, r0_write, r0_ready, r0_rsp_valid;
   logic [7:0] r0_addr, r0_wdata, r0_rsp_rdata;
   logic       r1_valid, r1_write, r1_ready, r1_rsp_valid;
   logic [7:0] r1_addr, r1_wdata, r1_rsp_rdata;
   logic       mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp;
   int n_fail;

   mem_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .r0_valid     (r0_valid),
      .r0_write     (r0_write),
      .r0_addr      (r0_addr),
      .r0_wdata     (r0_wdata),
      .r0_ready     (r0_ready),
      .r0_rsp_valid (r0_rsp_valid),
      .r0_rsp_rdata (r0_rsp_rdata),
      .r1_valid     (r1_valid),
      .r1_write     (r1_write),
      .r1_addr      (r1_addr),
      .r1_wdata     (r1_wdata),
      .r1_ready     (r1_ready),
      .r1_rsp_valid (r1_rsp_valid),
      .r1_rsp_rdata (r1_rsp_rdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory preloaded with addr ^ 0x5A; its reset blocks writes in the reset cycle.
   logic [7:0] mem [256];
   bit         init_done;
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= 8'(i) ^ 8'h5A;
         init_done <= 1'b1;
      end else if (mem_we && !reset) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input bit n, input bit w, input logic [7:0] a, input logic [7:0] d);
      if (n) begin
         r1_valid = 1'b1; r1_write = w; r1_addr = a; r1_wdata = d;
      end else begin
         r0_valid = 1'b1; r0_write = w; r0_addr = a; r0_wdata = d;
      end
      step;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      step;
   endtask

   task automatic test_reset;
      r0_valid = 1'b1;
      r1_valid = 1'b1;
      step;
      #1;
      n_cmp++; if (r0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_r0_ready got=%0b exp=0", r0_ready); end
      n_cmp++; if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_r1_ready got=%0b exp=0", r1_ready); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
      n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=00", mem_addr); end
      n_cmp++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata got=%h exp=00", mem_wdata); end
      n_cmp++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=00", {r0_rsp_valid, r1_rsp_valid}); end
      n_cmp++; if (r0_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_r0_rdata got=%h exp=00", r0_rsp_rdata); end
      n_cmp++; if (r1_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_r1_rdata got=%h exp=00", r1_rsp_rdata); end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      reset    = 1'b0;
      step;
   endtask

   task automatic test_single_write;
      r0_valid = 1'b1; r0_write = 1'b1; r0_addr = 8'h10; r0_wdata = 8'hA5;
      #1;
      n_cmp++; if (r0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_r0_ready got=%0b exp=1", r0_ready); end
      n_cmp++; if (r1_ready !== 1'b0) begin n_fail++; $display("FAIL wr_r1_ready got=%0b exp=0", r1_ready); end
      step;
      // garbage outside the handshake cycle must be ignored
      r0_valid = 1'b0; r0_addr = 8'h77; r0_wdata = 8'h00;
      #1;
      n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_acc_we got=%0b exp=1", mem_we); end
      n_cmp++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL wr_acc_addr got=%h exp=10", mem_addr); end
      n_cmp++; if (mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_acc_wdata got=%h exp=a5", mem_wdata); end
      n_cmp++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_acc_rsp got=%0b exp=0", r0_rsp_valid); end
      step;
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_we got=%0b exp=0", mem_we); end
      n_cmp++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL wr_hold_addr got=%h exp=10", mem_addr); end
      n_cmp++; if (r0_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_r0_rsp got=%0b exp=1", r0_rsp_valid); end
      n_cmp++; if (r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_r1_rsp got=%0b exp=0", r1_rsp_valid); end
      n_cmp++; if (r0_rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rdata_kept got=%h exp=00", r0_rsp_rdata); end
      step;
      n_cmp++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_once got=%0b exp=0", r0_rsp_valid); end
   endtask

   task automatic test_read_after_write;
      r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 8'h10; r1_wdata = 8'h00;
      #1;
      n_cmp++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL raw_r1_ready got=%0b exp=1", r1_ready); end
      step;
      r1_valid = 1'b0;
      #1;
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL raw_acc_we got=%0b exp=0", mem_we); end
      step;
      n_cmp++; if (r1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL raw_r1_rsp got=%0b exp=1", r1_rsp_valid); end
      n_cmp++; if (r1_rsp_rdata !== 8'hA5) begin n_fail++; $display("FAIL raw_r1_rdata got=%h exp=a5", r1_rsp_rdata); end
      n_cmp++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL raw_r0_rsp got=%0b exp=0", r0_rsp_valid); end
      step;
   endtask

   task automatic test_contention;
      logic [7:0] e0_rdy, e1_rdy, e0_rsp, e1_rsp;
      e0_rdy = 8'b0001_0001;
      e1_rdy = 8'b0100_0100;
      e0_rsp = 8'b0100_0100;
      e1_rsp = 8'b0001_0000;
      reset = 1'b1;
      r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 8'h01;
      r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 8'h02;
      step;
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_cmp++; if (r0_ready !== e0_rdy[c]) begin n_fail++; $display("FAIL cont_r0_ready c%0d got=%0b exp=%0b", c, r0_ready, e0_rdy[c]); end
         n_cmp++; if (r1_ready !== e1_rdy[c]) begin n_fail++; $display("FAIL cont_r1_ready c%0d got=%0b exp=%0b", c, r1_ready, e1_rdy[c]); end
         n_cmp++; if (r0_rsp_valid !== e0_rsp[c]) begin n_fail++; $display("FAIL cont_r0_rsp c%0d got=%0b exp=%0b", c, r0_rsp_valid, e0_rsp[c]); end
         n_cmp++; if (r1_rsp_valid !== e1_rsp[c]) begin n_fail++; $display("FAIL cont_r1_rsp c%0d got=%0b exp=%0b", c, r1_rsp_valid, e1_rsp[c]); end
         step;
      end
      n_cmp++; if (r0_rsp_rdata !== 8'h5B) begin n_fail++; $display("FAIL cont_r0_rdata got=%h exp=5b", r0_rsp_rdata); end
      n_cmp++; if (r1_rsp_rdata !== 8'h58) begin n_fail++; $display("FAIL cont_r1_rdata got=%h exp=58", r1_rsp_rdata); end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      step;
      step;
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp_b [4];
      logic       exp_rdy, exp_rsp;
      exp_b[0] = 8'h5A; exp_b[1] = 8'h5B; exp_b[2] = 8'h58; exp_b[3] = 8'h59;
      r0_write = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         if (k < 8 && k % 2 == 0) begin
            r0_valid = 1'b1;
            r0_addr  = 8'(k / 2);
         end
         if (k == 8)
            r0_valid = 1'b0;
         #1;
         exp_rdy = (k < 8) && (k % 2 == 0);
         exp_rsp = (k >= 2) && (k % 2 == 0);
         n_cmp++; if (r0_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready k%0d got=%0b exp=%0b", k, r0_ready, exp_rdy); end
         n_cmp++; if (r0_rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL b2b_rsp k%0d got=%0b exp=%0b", k, r0_rsp_valid, exp_rsp); end
         if (exp_rsp) begin
            n_cmp++; if (r0_rsp_rdata !== exp_b[(k-2)/2]) begin n_fail++; $display("FAIL b2b_rdata k%0d got=%h exp=%h", k, r0_rsp_rdata, exp_b[(k-2)/2]); end
         end
         if (k % 2 == 1) begin
            n_cmp++; if (mem_addr !== 8'(k / 2)) begin n_fail++; $display("FAIL b2b_addr k%0d got=%h exp=%h", k, mem_addr, 8'(k / 2)); end
         end
         step;
      end
   endtask

   task automatic test_reset_mid;
      r1_valid = 1'b1; r1_write = 1'b1; r1_addr = 8'h20; r1_wdata = 8'h3C;
      #1;
      n_cmp++; if (r1_ready !== 1'b1) begin n_fail++; $display("FAIL rm_r1_ready got=%0b exp=1", r1_ready); end
      step;
      r1_valid = 1'b0;
      reset    = 1'b1;
      #1;
      n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rm_acc_we got=%0b exp=1", mem_we); end
      step;
      reset = 1'b0;
      r0_valid = 1'b1; r0_write = 1'b0; r0_addr = 8'h20;
      r1_valid = 1'b1; r1_write = 1'b0; r1_addr = 8'h21;
      #1;
      n_cmp++; if (r1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_r1_rsp got=%0b exp=0", r1_rsp_valid); end
      n_cmp++; if (r0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_r0_rsp got=%0b exp=0", r0_rsp_valid); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rm_we got=%0b exp=0", mem_we); end
      n_cmp++; if ({mem_addr, mem_wdata} !== 16'h0000) begin n_fail++; $display("FAIL rm_addr_wdata got=%h exp=0000", {mem_addr, mem_wdata}); end
      n_cmp++; if ({r0_rsp_rdata, r1_rsp_rdata} !== 16'h0000) begin n_fail++; $display("FAIL rm_rdata got=%h exp=0000", {r0_rsp_rdata, r1_rsp_rdata}); end
      n_cmp++; if ({r0_ready, r1_ready} !== 2'b10) begin n_fail++; $display("FAIL rm_tie got=%b exp=10", {r0_ready, r1_ready}); end
      step;
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      #1;
      n_cmp++; if (mem_addr !== 8'h20) begin n_fail++; $display("FAIL rm_acc_addr got=%h exp=20", mem_addr); end
      step;
      n_cmp++; if (r0_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rm_r0_rsp2 got=%0b exp=1", r0_rsp_valid); end
      n_cmp++; if (r0_rsp_rdata !== 8'h7A) begin n_fail++; $display("FAIL rm_aborted_wr got=%h exp=7a", r0_rsp_rdata); end
      step;
   endtask

   task automatic test_boundary;
      run_txn(1'b0, 1'b1, 8'hFF, 8'hFF);
      n_cmp++; if (r0_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bd_wr_rsp got=%0b exp=1", r0_rsp_valid); end
      run_txn(1'b1, 1'b0, 8'hFF, 8'h00);
      n_cmp++; if (r1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bd_rd_ff_rsp got=%0b exp=1", r1_rsp_valid); end
      n_cmp++; if (r1_rsp_rdata !== 8'hFF) begin n_fail++; $display("FAIL bd_rd_ff got=%h exp=ff", r1_rsp_rdata); end
      run_txn(1'b0, 1'b0, 8'h00, 8'h00);
      n_cmp++; if (r0_rsp_rdata !== 8'h5A) begin n_fail++; $display("FAIL bd_rd_00 got=%h exp=5a", r0_rsp_rdata); end
      step;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b1;
      r0_valid = 1'b0; r0_write = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
      r1_valid = 1'b0; r1_write = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
      test_reset;
      test_single_write;
      test_read_after_write;
      test_contention;
      test_back_to_back;
      test_reset_mid;
      test_boundary;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached without finishing");
      $fatal(1);
   end

endmodule
